// File: rtl/ct_stream_out_if.sv
// Beat stream carrying repacked memory words from ct_stream_out to its sink.
interface ct_stream_out_if #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SEL_W = 1
);
    logic [OUT_W-1:0] out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, out_ch, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_ch, out_valid, out_last, output out_ready);
endinterface

// File: rtl/ct_stream_out.sv
// Ciphertext read-out engine: walks the selected word memories in ascending order and
// repacks their words LSB-first into OUT_W-bit stream beats, zero-padding each channel's tail.
module ct_stream_out #(
    parameter int unsigned M       = 67,
    parameter int unsigned DIGIT   = 4,
    parameter int unsigned N_WORDS = 21,
    parameter int unsigned CH      = 2,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int unsigned WORD_W = M * DIGIT,
    localparam int unsigned SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [CH-1:0]     ch_mask,
    output logic              mem_rd,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_dout,
    ct_stream_out_if.master   so,
    output logic              busy,
    output logic              done
);
    localparam int unsigned BUF_W  = WORD_W + OUT_W - 1;
    localparam int unsigned CNT_W  = $clog2(BUF_W + 1);
    localparam int unsigned WCNT_W = $clog2(N_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_FILL, S_WAIT, S_EMIT, S_FIN} state_e;

    state_e              state_q, state_n;
    logic [CH-1:0]       mask_q, mask_n;
    logic [BUF_W-1:0]    buf_q, buf_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_n;
    logic                mem_rd_n;
    logic [SEL_W-1:0]    mem_sel_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [OUT_W-1:0]    out_data_n;
    logic [SEL_W-1:0]    out_ch_n;
    logic                out_valid_n, out_last_n, busy_n, done_n;
    logic [SEL_W-1:0]    sel_idx;
    logic                need_bits, words_left, beat_taken;

    assign need_bits  = cnt_q < CNT_W'(OUT_W);
    assign words_left = wcnt_q < WCNT_W'(N_WORDS);
    assign beat_taken = so.out_valid && so.out_ready;

    // Lowest still-pending channel of the latched mask.
    always_comb begin
        sel_idx = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_idx = SEL_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_n = S_SEL;
            S_SEL:  state_n = (mask_q != '0) ? S_FILL : S_FIN;
            S_FILL: begin
                if (need_bits && words_left)     state_n = S_WAIT;
                else if (!need_bits || cnt_q != '0) state_n = S_EMIT;
                else                             state_n = S_SEL;
            end
            // First WAIT cycle issues the read, second captures the returned word.
            S_WAIT: if (!mem_rd) state_n = S_FILL;
            S_EMIT: if (beat_taken) state_n = S_FILL;
            S_FIN:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mask_n      = mask_q;
        buf_n       = buf_q;
        cnt_n       = cnt_q;
        wcnt_n      = wcnt_q;
        mem_rd_n    = 1'b0;
        mem_sel_n   = mem_sel;
        mem_addr_n  = mem_addr;
        out_data_n  = so.out_data;
        out_ch_n    = so.out_ch;
        out_valid_n = so.out_valid;
        out_last_n  = so.out_last;
        unique case (state_q)
            S_IDLE: if (start) mask_n = ch_mask;
            S_SEL: begin
                if (mask_q != '0) begin
                    mask_n     = mask_q & ~(CH'(1) << sel_idx);
                    mem_sel_n  = sel_idx;
                    mem_addr_n = '0;
                    wcnt_n     = '0;
                    buf_n      = '0;
                    cnt_n      = '0;
                end
            end
            S_FILL: begin
                if (need_bits && words_left) begin
                    mem_rd_n = 1'b1;
                end else if (!need_bits || cnt_q != '0) begin
                    // Bits above cnt are always zero, so padding is just a count bump.
                    if (need_bits) cnt_n = CNT_W'(OUT_W);
                    out_valid_n = 1'b1;
                    out_data_n  = buf_q[OUT_W-1:0];
                    out_ch_n    = mem_sel;
                    out_last_n  = !words_left && (cnt_q <= CNT_W'(OUT_W)) && (mask_q == '0);
                end
            end
            S_WAIT: begin
                if (!mem_rd) begin
                    buf_n      = buf_q | (BUF_W'(mem_dout) << cnt_q);
                    cnt_n      = cnt_q + CNT_W'(WORD_W);
                    mem_addr_n = mem_addr + 1'b1;
                    wcnt_n     = wcnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (beat_taken) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    buf_n       = buf_q >> OUT_W;
                    cnt_n       = need_bits ? '0 : cnt_q - CNT_W'(OUT_W);
                end
            end
            default: ;
        endcase
        busy_n = (state_n != S_IDLE) && (state_n != S_FIN);
        done_n = (state_n == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            mask_q       <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            mem_rd       <= 1'b0;
            mem_sel      <= '0;
            mem_addr     <= '0;
            so.out_data  <= '0;
            so.out_ch    <= '0;
            so.out_valid <= 1'b0;
            so.out_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mask_q       <= mask_n;
            buf_q        <= buf_n;
            cnt_q        <= cnt_n;
            wcnt_q       <= wcnt_n;
            mem_rd       <= mem_rd_n;
            mem_sel      <= mem_sel_n;
            mem_addr     <= mem_addr_n;
            so.out_data  <= out_data_n;
            so.out_ch    <= out_ch_n;
            so.out_valid <= out_valid_n;
            so.out_last  <= out_last_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end
endmodule

// File: tb/tb_ct_stream_out.sv
// Directed bench for ct_stream_out: three parameter sets, table-driven beat checks
// plus hand sequences for empty mask, restart attempts and mid-transfer reset.
module tb_ct_stream_out;
    localparam int unsigned B_WW  = 268;
    localparam int unsigned B_BPC = 176;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_b;

    int n_cmp = 0;
    int n_err = 0;

    // Config A: 16-bit words, 3 words, 32-bit beats
    logic        a_start, a_rd, a_busy, a_done;
    logic [0:0]  a_mask, a_sel;
    logic [1:0]  a_addr;
    logic [15:0] a_dout;
    logic [15:0] mem_a [3];
    ct_stream_out_if #(.OUT_W(32), .SEL_W(1)) a_so ();
    ct_stream_out #(.M(8), .DIGIT(2), .N_WORDS(3), .CH(1), .OUT_W(32)) u_a (
        .clk(clk), .rst_b(rst_b), .start(a_start), .ch_mask(a_mask), .mem_rd(a_rd),
        .mem_sel(a_sel), .mem_addr(a_addr), .mem_dout(a_dout), .so(a_so),
        .busy(a_busy), .done(a_done));
    always @(posedge clk) if (a_rd) a_dout <= (a_addr < 2'd3) ? mem_a[a_addr] : 16'h0;

    // Config C: beat width equals word width
    logic        c_start, c_rd, c_busy, c_done;
    logic [0:0]  c_mask, c_sel;
    logic [1:0]  c_addr;
    logic [15:0] c_dout;
    logic [15:0] mem_c [4];
    ct_stream_out_if #(.OUT_W(16), .SEL_W(1)) c_so ();
    ct_stream_out #(.M(8), .DIGIT(2), .N_WORDS(4), .CH(1), .OUT_W(16)) u_c (
        .clk(clk), .rst_b(rst_b), .start(c_start), .ch_mask(c_mask), .mem_rd(c_rd),
        .mem_sel(c_sel), .mem_addr(c_addr), .mem_dout(c_dout), .so(c_so),
        .busy(c_busy), .done(c_done));
    always @(posedge clk) if (c_rd) c_dout <= mem_c[c_addr];

    // Config B: defaults
    logic            b_start, b_rd, b_busy, b_done;
    logic [1:0]      b_mask;
    logic [0:0]      b_sel;
    logic [4:0]      b_addr;
    logic [B_WW-1:0] b_dout;
    logic [B_WW-1:0] mem_b [2][21];
    logic [5631:0]   chan_str [2];
    ct_stream_out_if #(.OUT_W(32), .SEL_W(1)) b_so ();
    ct_stream_out u_b (
        .clk(clk), .rst_b(rst_b), .start(b_start), .ch_mask(b_mask), .mem_rd(b_rd),
        .mem_sel(b_sel), .mem_addr(b_addr), .mem_dout(b_dout), .so(b_so),
        .busy(b_busy), .done(b_done));
    always @(posedge clk) if (b_rd) b_dout <= (b_addr < 5'd21) ? mem_b[b_sel][b_addr] : '0;

    typedef struct {
        int          cfg;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0] mask;
        int         mode;
        int         restart_at;
        int         exp_beats;
        int         exp_last_at;
    } bvec_t;

    beat_t small_tab [6];
    bvec_t btab [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [B_WW-1:0] gen_word(input int c, input int a);
        logic [287:0] t;
        for (int j = 0; j < 9; j++)
            t[j*32 +: 32] = (32'(c * 4096 + a * 16 + j + 1) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        return t[B_WW-1:0];
    endfunction

    task automatic run_small(input int cfg);
        logic [31:0] got_d [$];
        logic        got_l [$];
        int dones = 0, busy_bad = 0, k = 0;
        @(negedge clk);
        if (cfg == 0) a_start = 1'b1; else c_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        c_start = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cfg == 0) begin
                if (a_so.out_valid) begin got_d.push_back(a_so.out_data); got_l.push_back(a_so.out_last); end
                if (a_done) begin dones++; if (a_busy) busy_bad++; end
            end else begin
                if (c_so.out_valid) begin got_d.push_back(32'(c_so.out_data)); got_l.push_back(c_so.out_last); end
                if (c_done) begin dones++; if (c_busy) busy_bad++; end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            if (small_tab[i].cfg == cfg) begin
                check($sformatf("small%0d_data%0d", cfg, k), (k < got_d.size()) ? got_d[k] : 32'hDEAD_BEEF, small_tab[i].data);
                check($sformatf("small%0d_last%0d", cfg, k), (k < got_l.size()) ? got_l[k] : 1'bx, small_tab[i].last);
                k++;
            end
        end
        check($sformatf("small%0d_beats", cfg), got_d.size(), k);
        check($sformatf("small%0d_dones", cfg), dones, 1);
        check($sformatf("small%0d_busy_at_done", cfg), busy_bad, 0);
    endtask

    task automatic run_b(input logic [1:0] mask, input int mode, input int restart_at,
                         input int exp_beats, input int exp_last_at);
        int beats = 0, data_err = 0, ch_err = 0, stall_err = 0;
        int last_at = 0, last_cnt = 0, addr_err = 0, n_sel = 0, g, k, ec;
        int hits [2][32];
        int sel_list [2];
        bit done_seen = 0, busy_at_done = 0, prev_stall = 0, rdy;
        logic [31:0] prev_data;
        logic        prev_ch, prev_last;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 32; a++) hits[c][a] = 0;
            if (mask[c]) begin sel_list[n_sel] = c; n_sel++; end
        end
        @(negedge clk);
        b_mask  = mask;
        b_start = 1'b1;
        for (int cyc = 0; cyc < 8000 && !done_seen; cyc++) begin
            @(negedge clk);
            b_start = (cyc == restart_at);
            b_mask  = (cyc == restart_at) ? ~mask : mask;
            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = (cyc % 2 == 0);
                default: rdy = 1'b1;
            endcase
            b_so.out_ready = rdy;
            if (prev_stall && (!b_so.out_valid || b_so.out_data !== prev_data ||
                               b_so.out_ch !== prev_ch || b_so.out_last !== prev_last))
                stall_err++;
            if (b_rd) begin
                if (b_addr < 5'd21) hits[b_sel][b_addr]++;
                else addr_err++;
            end
            if (b_so.out_valid && rdy) begin
                g = beats / B_BPC;
                k = beats % B_BPC;
                if (g >= n_sel) begin
                    data_err++;
                end else begin
                    ec = sel_list[g];
                    if (b_so.out_ch !== 1'(ec)) ch_err++;
                    if (b_so.out_data !== chan_str[ec][k*32 +: 32]) data_err++;
                end
                if (b_so.out_last) begin last_cnt++; last_at = beats + 1; end
                beats++;
            end
            prev_stall = b_so.out_valid && !rdy;
            prev_data  = b_so.out_data;
            prev_ch    = b_so.out_ch;
            prev_last  = b_so.out_last;
            if (b_done) begin done_seen = 1'b1; busy_at_done = b_busy; end
        end
        b_start = 1'b0;
        b_so.out_ready = 1'b1;
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 21; a++)
                if (hits[c][a] != (mask[c] ? 1 : 0)) addr_err++;
        check($sformatf("b%b_done_seen", mask), done_seen, 1);
        check($sformatf("b%b_busy_at_done", mask), busy_at_done, 0);
        check($sformatf("b%b_beats", mask), beats, exp_beats);
        check($sformatf("b%b_data_errs", mask), data_err, 0);
        check($sformatf("b%b_ch_errs", mask), ch_err, 0);
        check($sformatf("b%b_stall_errs", mask), stall_err, 0);
        check($sformatf("b%b_last_at", mask), last_at, exp_last_at);
        check($sformatf("b%b_last_count", mask), last_cnt, (exp_last_at != 0) ? 1 : 0);
        check($sformatf("b%b_addr_errs", mask), addr_err, 0);
    endtask

    initial begin
        int beats, idle_act;
        small_tab[0] = '{0, 32'h2222_1111, 1'b0};
        small_tab[1] = '{0, 32'h0000_3333, 1'b1};
        small_tab[2] = '{1, 32'h0000_A001, 1'b0};
        small_tab[3] = '{1, 32'h0000_5A02, 1'b0};
        small_tab[4] = '{1, 32'h0000_C3C3, 1'b0};
        small_tab[5] = '{1, 32'h0000_0FF0, 1'b1};
        btab[0] = '{2'b01, 0, -1,  176, 176};
        btab[1] = '{2'b11, 1, 100, 352, 352};
        btab[2] = '{2'b10, 2, 40,  176, 176};
        btab[3] = '{2'b00, 0, -1,  0,   0};
        btab[4] = '{2'b11, 0, 300, 352, 352};

        mem_a[0] = 16'h1111; mem_a[1] = 16'h2222; mem_a[2] = 16'h3333;
        mem_c[0] = 16'hA001; mem_c[1] = 16'h5A02; mem_c[2] = 16'hC3C3; mem_c[3] = 16'h0FF0;
        for (int c = 0; c < 2; c++) begin
            chan_str[c] = '0;
            for (int a = 0; a < 21; a++) begin
                mem_b[c][a] = gen_word(c, a);
                chan_str[c][a*B_WW +: B_WW] = gen_word(c, a);
            end
        end

        rst_b = 1'b1;
        a_start = 1'b0; a_mask = 1'b1; a_so.out_ready = 1'b1;
        c_start = 1'b0; c_mask = 1'b1; c_so.out_ready = 1'b1;
        b_start = 1'b0; b_mask = 2'b00; b_so.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_b_ctrl", {b_busy, b_done, b_so.out_valid, b_so.out_last, b_rd, b_sel, b_addr, b_so.out_ch}, '0);
        check("reset_b_data", b_so.out_data, 32'h0);
        check("reset_ac_ctrl", {a_busy, a_done, a_so.out_valid, a_rd, c_busy, c_done, c_so.out_valid, c_rd}, '0);
        rst_b = 1'b0;

        run_small(0);
        run_small(1);

        // Empty mask: SEL then FIN, done two cycles after start
        @(negedge clk);
        b_mask = 2'b00; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check("empty_busy_c1", b_busy, 1'b1);
        check("empty_done_c1", b_done, 1'b0);
        @(negedge clk);
        check("empty_done_c2", b_done, 1'b1);
        check("empty_valid_c2", b_so.out_valid, 1'b0);
        @(negedge clk);
        check("empty_done_c3", b_done, 1'b0);

        for (int i = 0; i < 5; i++)
            run_b(btab[i].mask, btab[i].mode, btab[i].restart_at, btab[i].exp_beats, btab[i].exp_last_at);

        // Reset at beat 50 of a two-channel transfer
        @(negedge clk);
        b_mask = 2'b11; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 2000 && beats < 50; cyc++) begin
            if (b_so.out_valid && b_so.out_ready) beats++;
            if (beats < 50) @(negedge clk);
        end
        check("rst_reach_beat50", beats, 50);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("midrst_ctrl", {b_busy, b_done, b_so.out_valid, b_so.out_last, b_rd, b_sel, b_addr, b_so.out_ch}, '0);
        check("midrst_data", b_so.out_data, 32'h0);
        idle_act = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (b_rd || b_so.out_valid || b_busy || b_done) idle_act++;
        end
        check("midrst_stays_idle", idle_act, 0);
        run_b(2'b01, 1, -1, 176, 176);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
